// File: rtl/muldiv_sequencer_pkg.sv
// Shared core definitions for the iterative RISC-V M-extension sequencer.
package muldiv_sequencer_pkg;

    localparam int unsigned CORE_XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Divide and remainder ops live in the upper half of the funct3 space.
    function automatic logic op_is_div(input funct3_e f);
        return f[2];
    endfunction

    // op_a is treated as two's complement for these ops.
    function automatic logic op_signed_a(input funct3_e f);
        return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
    endfunction

    // op_b is treated as two's complement for these ops.
    function automatic logic op_signed_b(input funct3_e f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// cycle on operand magnitudes, followed by a single sign-fix cycle.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            we,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned AW    = XLEN + 2;
    localparam int unsigned PW    = 2 * XLEN;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    funct3_e           f3_q, f3_d;
    logic [4:0]        rd_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_d;
    logic              busy_d, done_d, we_d;

    // Input decode for the accept cycle.
    funct3_e           f3_in;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;

    // Shared add/subtract datapath.
    logic [XLEN:0]     add_x, add_y, add_y_eff;
    logic              add_sub;
    logic [AW-1:0]     add_full;
    logic              no_borrow;

    // Sign correction and result selection.
    logic [PW-1:0]     prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Stall covers the accept cycle and every cycle the op is computing.
    assign stall = (start && (state_q == IDLE)) || (state_q == CALC) || (state_q == FIX);

    // Operand magnitudes and one-step special cases for an incoming op.
    always_comb begin
        f3_in       = funct3_e'(funct3);
        neg_a       = op_signed_a(f3_in) && op_a[XLEN-1];
        neg_b       = op_signed_b(f3_in) && op_b[XLEN-1];
        mag_a       = neg_a ? (-op_a) : op_a;
        mag_b       = neg_b ? (-op_b) : op_b;
        div_zero    = funct3[2] && (op_b == '0);
        div_ovf     = ((f3_in == F3_DIV) || (f3_in == F3_REM)) &&
                      (op_a == MOST_NEG) && (op_b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : op_a;
        end
    end

    // One iteration: conditional add of the multiplicand, or trial subtract of the divisor.
    always_comb begin
        add_x   = {1'b0, hi_q};
        add_y   = '0;
        add_sub = 1'b0;
        if (op_is_div(f3_q)) begin
            add_x   = {hi_q, lo_q[XLEN-1]};
            add_y   = {1'b0, b_q};
            add_sub = 1'b1;
        end else if (lo_q[0]) begin
            add_y   = {1'b0, b_q};
        end
        add_y_eff = add_sub ? ~add_y : add_y;
        add_full  = AW'(add_x) + AW'(add_y_eff) + AW'(add_sub);
        no_borrow = add_full[XLEN+1];
    end

    // Restore signs on the magnitude result and pick the requested half.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (sa_q ^ sb_q) ? (-prod) : prod;
        quo_fix  = (sa_q ^ sb_q) ? (-lo_q) : lo_q;
        rem_fix  = sa_q ? (-hi_q) : hi_q;
        fix_res  = '0;
        case (f3_q)
            F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[PW-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = quo_fix;
            F3_REM, F3_REMU:              fix_res = rem_fix;
            default:                      fix_res = '0;
        endcase
    end

    // Next-state, datapath register updates and registered output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_out;
        sa_d     = sa_q;
        sb_d     = sb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    f3_d = f3_in;
                    rd_d = rd_in;
                    sa_d = neg_a;
                    sb_d = neg_b;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = mag_a;
                        b_d     = mag_b;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (op_is_div(f3_q)) begin
                    hi_d = no_borrow ? add_full[XLEN-1:0] : add_x[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], no_borrow};
                end else begin
                    hi_d = add_full[XLEN:1];
                    lo_d = {add_full[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An aborted op must leave the visible write-back registers untouched.
        if (flush) begin
            state_d  = IDLE;
            result_d = result;
            rd_d     = rd_out;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        we_d   = (state_d == DONE) && (rd_d != 5'd0);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= F3_MUL;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            result  <= '0;
            rd_out  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            we      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            result  <= result_d;
            rd_out  <= rd_d;
            busy    <= busy_d;
            done    <= done_d;
            we      <= we_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: directed corner ops plus random ops against an
// arithmetic reference model of the M-extension semantics.
module tb_muldiv_sequencer;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy, stall, done, we;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] last_result;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .we     (we),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, ps;
        longint unsigned ua, ub, pu;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (f)
            3'd0: begin pu = ua * ub; r = pu[31:0]; end
            3'd1: begin ps = sa * sb; r = ps[63:32]; end
            3'd2: begin ps = sa * longint'(ub); r = ps[63:32]; end
            3'd3: begin pu = ua * ub; r = pu[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin ps = sa / sb; r = ps[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin pu = ua / ub; r = pu[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin ps = sa % sb; r = ps[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin pu = ua % ub; r = pu[31:0]; end
            end
        endcase
        return r;
    endfunction

    // Cycles from the accept edge to the cycle with done high.
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        bit is_div, signed_div;
        is_div     = (f >= 3'd4);
        signed_div = (f == 3'd4) || (f == 3'd6);
        if (is_div && (b == 0 || (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op and check latency, stall/busy behaviour and write-back.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit hold_start, input string tag);
        logic [31:0] exp_r;
        int          exp_lat, lat;
        bit          stall_ok, seen_done;
        exp_r   = ref_result(f, a, b);
        exp_lat = ref_latency(f, a, b);
        funct3  = f;
        op_a    = a;
        op_b    = b;
        rd_in   = rd;
        start   = 1'b1;
        #1;
        check({tag, "_stall_accept"}, stall, 1);
        lat      = 0;
        stall_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            seen_done = done;
            if (seen_done) begin
                lat = n;
                break;
            end
            if (!stall || !busy) stall_ok = 1'b0;
            if (hold_start) begin
                funct3 = 3'($urandom_range(0, 7));
                op_a   = $urandom;
                op_b   = $urandom;
                rd_in  = 5'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp_r);
        check({tag, "_we"}, we, (rd != 5'd0));
        check({tag, "_rd"}, rd_out, rd);
        check({tag, "_stall_done"}, stall, 0);
        check({tag, "_stall_run"}, stall_ok, 1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_result_hold"}, result, exp_r);
        last_result = exp_r;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_rd"}, rd_out, 0);
    endtask

    initial begin
        int done_cnt;
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        last_result = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_zero("reset");

        run_op(3'd0, 32'd7, -32'd3, 5'd1, 1'b0, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b0, "mulh");
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3, 1'b0, "mulhu");
        run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b0, "mulhsu");
        run_op(3'd4, -32'd7, 32'd2, 5'd5, 1'b0, "div");
        run_op(3'd6, -32'd7, 32'd2, 5'd6, 1'b0, "rem");
        run_op(3'd5, 32'd7, 32'd2, 5'd7, 1'b0, "divu");
        run_op(3'd5, 32'd5, 32'd0, 5'd8, 1'b0, "divu_zero");
        run_op(3'd6, 32'd5, 32'd0, 5'd9, 1'b0, "rem_zero");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, "rem_ovf");
        run_op(3'd0, 32'd1234, 32'd5678, 5'd0, 1'b1, "hold_rd0");

        // Abort an in-flight divide partway through the iterations.
        funct3 = 3'd4;
        op_a   = 32'd100;
        op_b   = 32'd7;
        rd_in  = 5'd12;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("flush_no_done", done_cnt, 0);
        check("flush_result_hold", result, last_result);
        run_op(3'd4, 32'd100, 32'd7, 5'd12, 1'b0, "after_flush");

        // Flush in the same cycle as start blocks acceptance.
        funct3 = 3'd5;
        op_a   = 32'd9;
        op_b   = 32'd3;
        rd_in  = 5'd13;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", busy, 0);
        check("flush_start_rd", rd_out, 12);

        // Reset in the middle of an iteration run.
        funct3 = 3'd0;
        op_a   = 32'd3;
        op_b   = 32'd4;
        rd_in  = 5'd14;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush = 1'b0;
        check_idle_zero("reset_mid");

        for (int k = 0; k < 150; k++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
